// File: rtl/melody_pkg.sv
// Shared state encodings, reserved field values and song ROM word field helpers for the
// melody sequencer.
package melody_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t FETCH = 3'd1;
  localparam state_t LATCH = 3'd2;
  localparam state_t PLAY  = 3'd3;
  localparam state_t GAP   = 3'd4;
  localparam state_t NEXT  = 3'd5;
  localparam state_t WRAP  = 3'd6;

  localparam int unsigned REST_NOTE = 0;
  localparam int unsigned END_DUR   = 0;

  // ROM word is {note, dur}; callers narrow the result to their field width.
  function automatic logic [31:0] word_note(input logic [31:0] word, input int unsigned dur_w);
    return word >> dur_w;
  endfunction

  function automatic logic [31:0] word_dur(input logic [31:0] word, input int unsigned dur_w);
    return word & ((32'd1 << dur_w) - 32'd1);
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Player / song ROM / tone mux signals of the melody sequencer.
// The pause input exists only when MELODY_PAUSE_EN is defined.
interface melody_sequencer_if #(
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned DUR_W  = 8,
  parameter int unsigned ADDR_W = 6
);
  logic                    start;
  logic                    stop;
  logic                    loop_en;
`ifdef MELODY_PAUSE_EN
  logic                    pause;
`endif
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       sel;
  logic                    mute;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, stop, loop_en, rom_data,
`ifdef MELODY_PAUSE_EN
    input  pause,
`endif
    output rom_addr, sel, mute, busy, done
  );

  modport slave (
    output start, stop, loop_en, rom_data,
`ifdef MELODY_PAUSE_EN
    output pause,
`endif
    input  rom_addr, sel, mute, busy, done
  );
endinterface

// File: rtl/tick_divider.sv
// Duration tick prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
module tick_divider #(
  parameter int unsigned DIV = 10
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end
endmodule

// File: rtl/melody_sequencer.sv
// Steps through a {note, dur} song ROM, drives the tone mux select and mute, and inserts an
// articulation gap after each note. Optional pause input guarded by MELODY_PAUSE_EN.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned SONG_LEN  = 64,
  parameter int unsigned GAP_TICKS = 2
) (
  input logic                clock,
  input logic                rst_n,
  melody_sequencer_if.master bus
);
  localparam int unsigned       DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned       GAP_LAST  = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] sel_q, sel_d;
  logic              mute_q, mute_d;
  logic              done_q, done_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              tick, clr, hold;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = NOTE_W'(word_note(32'(bus.rom_data), DUR_W));
  assign rom_dur  = DUR_W'(word_dur(32'(bus.rom_data), DUR_W));

`ifdef MELODY_PAUSE_EN
  assign hold = bus.pause && ((state_q == PLAY) || (state_q == GAP));
`else
  assign hold = 1'b0;
`endif

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (!hold),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    mute_d  = mute_q;
    done_d  = 1'b0;
    dur_d   = dur_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    if ((state_q != IDLE) && bus.stop) begin
      state_d = IDLE;
      addr_d  = '0;
      mute_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          mute_d = 1'b1;
          if (bus.start && !bus.stop) begin
            addr_d  = '0;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LATCH;
        LATCH: begin
          if (rom_dur == DUR_W'(END_DUR)) begin
            state_d = WRAP;
          end else begin
            sel_d   = rom_note;
            mute_d  = (rom_note == NOTE_W'(REST_NOTE));
            dur_d   = rom_dur;
            cnt_d   = '0;
            clr     = 1'b1;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            if (cnt_q == dur_q - DUR_ONE) begin
              cnt_d  = '0;
              mute_d = 1'b1;
              if (GAP_TICKS == 0) begin
                state_d = NEXT;
              end else begin
                clr     = 1'b1;
                state_d = GAP;
              end
            end else begin
              cnt_d = cnt_q + DUR_ONE;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt_q == DUR_W'(GAP_LAST)) begin
              cnt_d   = '0;
              state_d = NEXT;
            end else begin
              cnt_d = cnt_q + DUR_ONE;
            end
          end
        end
        NEXT: begin
          if (addr_q == LAST_ADDR) begin
            state_d = WRAP;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = FETCH;
          end
        end
        WRAP: begin
          addr_d = '0;
          if (bus.loop_en) begin
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            mute_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      mute_q  <= 1'b1;
      done_q  <= 1'b0;
      dur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      mute_q  <= mute_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pause forces silence without disturbing the note's own mute state.
  assign bus.rom_addr = addr_q;
  assign bus.sel      = sel_q;
  assign bus.mute     = mute_q | hold;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with DIV=10, GAP_TICKS=1, SONG_LEN=4 and a registered
// song ROM model; pause scenario only when MELODY_PAUSE_EN is defined.
module tb_melody_sequencer;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int LOG_N = 400;

  logic clock;
  logic rst_n;

  melody_sequencer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus ();

  melody_sequencer #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .NOTE_W    (NOTE_W),
    .DUR_W     (DUR_W),
    .ADDR_W    (ADDR_W),
    .SONG_LEN  (4),
    .GAP_TICKS (1)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NOTE_W+DUR_W-1:0] rom [0:63];

  always_ff @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int mute_log [0:LOG_N-1];
  int sel_log  [0:LOG_N-1];
  int busy_log [0:LOG_N-1];
  int addr_log [0:LOG_N-1];
  int unmute   [0:15];
  int first_unmute, done_cnt, done_at, busy_hi;
  int stop_at, rst_at, pause_from, pause_to;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_rom(input int n0, input int d0, input int n1, input int d1,
                          input int n2, input int d2, input int n3, input int d3);
    for (int a = 0; a < 64; a++) rom[a] = '0;
    rom[0] = {NOTE_W'(n0), DUR_W'(d0)};
    rom[1] = {NOTE_W'(n1), DUR_W'(d1)};
    rom[2] = {NOTE_W'(n2), DUR_W'(d2)};
    rom[3] = {NOTE_W'(n3), DUR_W'(d3)};
  endtask

  // Caller drives cycle-0 inputs; log index i is the i-th falling edge afterwards.
  task automatic observe(input int n);
    first_unmute = -1;
    done_cnt     = 0;
    done_at      = -1;
    busy_hi      = 0;
    for (int s = 0; s < 16; s++) unmute[s] = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      bus.start   = 1'b0;
      mute_log[i] = int'(bus.mute);
      sel_log[i]  = int'(bus.sel);
      busy_log[i] = int'(bus.busy);
      addr_log[i] = int'(bus.rom_addr);
      if (!bus.mute) begin
        unmute[bus.sel]++;
        if (first_unmute < 0) first_unmute = i;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (bus.busy) busy_hi++;
      bus.stop = (i == stop_at);
      rst_n    = (i != rst_at);
`ifdef MELODY_PAUSE_EN
      bus.pause = (i >= pause_from) && (i < pause_to);
`endif
    end
    bus.stop = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic start_song();
    @(negedge clock);
    bus.start = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
`ifdef MELODY_PAUSE_EN
    bus.pause   = 1'b0;
`endif
    stop_at    = -1;
    rst_at     = -1;
    pause_from = -1;
    pause_to   = -1;
    load_rom(3, 2, 5, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check_eq("reset_addr", int'(bus.rom_addr), 0);
    check_eq("reset_sel", int'(bus.sel), 0);
    check_eq("reset_mute", int'(bus.mute), 1);
    check_eq("reset_busy", int'(bus.busy), 0);
    check_eq("reset_done", int'(bus.done), 0);

    // Basic: FETCH 1, LATCH 2, PLAY 3..22, GAP 23..32, PLAY(5) 36..45, WRAP 59, done 60.
    start_song();
    observe(62);
    check_eq("basic_busy_fetch", busy_log[1], 1);
    check_eq("basic_mute_latch", mute_log[2], 1);
    check_eq("basic_first_unmute", first_unmute, 3);
    check_eq("basic_sel3_cycles", unmute[3], 20);
    check_eq("basic_gap_mute", mute_log[23], 1);
    check_eq("basic_gap_sel", sel_log[32], 3);
    check_eq("basic_latch2_mute", mute_log[35], 1);
    check_eq("basic_sel5_start", sel_log[36], 5);
    check_eq("basic_sel5_mute", mute_log[36], 0);
    check_eq("basic_sel5_cycles", unmute[5], 10);
    check_eq("basic_wrap_busy", busy_log[59], 1);
    check_eq("basic_done_at", done_at, 60);
    check_eq("basic_done_cnt", done_cnt, 1);
    check_eq("basic_idle_busy", busy_log[60], 0);
    check_eq("basic_idle_addr", addr_log[60], 0);

    // Rest note: 30-cycle PLAY fully muted with sel=0.
    load_rom(0, 3, 0, 0, 0, 0, 0, 0);
    start_song();
    observe(50);
    check_eq("rest_sel", sel_log[3], 0);
    check_eq("rest_busy", busy_log[20], 1);
    check_eq("rest_unmuted", first_unmute, -1);
    check_eq("rest_done_at", done_at, 47);

    // Loop: 93-cycle pass, three passes in 1..280, stop afterwards.
    load_rom(1, 1, 2, 1, 3, 1, 4, 1);
    bus.loop_en = 1'b1;
    stop_at = 281;
    start_song();
    observe(282);
    stop_at = -1;
    bus.loop_en = 1'b0;
    check_eq("loop_addr_last", addr_log[92], 3);
    check_eq("loop_addr_wrap", addr_log[94], 0);
    check_eq("loop_sel_pass2", sel_log[96], 1);
    check_eq("loop_mute_pass2", mute_log[96], 0);
    check_eq("loop_word0_cycles", unmute[1], 30);
    check_eq("loop_word3_cycles", unmute[4], 30);
    check_eq("loop_busy_cycles", busy_hi, 281);
    check_eq("loop_done_cnt", done_cnt, 0);
    check_eq("loop_stopped", busy_log[282], 0);

    // Abort mid-PLAY of word 1 (PLAY 36..45), then start+stop together.
    load_rom(3, 2, 5, 1, 0, 0, 0, 0);
    stop_at = 40;
    start_song();
    observe(70);
    stop_at = -1;
    check_eq("abort_before_sel", sel_log[40], 5);
    check_eq("abort_before_mute", mute_log[40], 0);
    check_eq("abort_busy", busy_log[41], 0);
    check_eq("abort_mute", mute_log[41], 1);
    check_eq("abort_addr", addr_log[41], 0);
    check_eq("abort_done_cnt", done_cnt, 0);
    @(negedge clock);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    observe(6);
    check_eq("startstop_busy", busy_hi, 0);

    // Reset during GAP (23..32): reset values seen at 26, then replay from address 0.
    rst_at = 25;
    start_song();
    observe(30);
    rst_at = -1;
    check_eq("rst_gap_busy_before", busy_log[25], 1);
    check_eq("rst_addr", addr_log[26], 0);
    check_eq("rst_sel", sel_log[26], 0);
    check_eq("rst_mute", mute_log[26], 1);
    check_eq("rst_busy_cycles", busy_hi, 25);
    check_eq("rst_no_done", done_cnt, 0);
    start_song();
    observe(62);
    check_eq("replay_first_unmute", first_unmute, 3);
    check_eq("replay_sel3_cycles", unmute[3], 20);
    check_eq("replay_done_at", done_at, 60);

`ifdef MELODY_PAUSE_EN
    // Pause 25 cycles from PLAY cycle 12: note ends 55 cycles after PLAY entry at 3.
    load_rom(4, 3, 0, 0, 0, 0, 0, 0);
    pause_from = 14;
    pause_to   = 39;
    start_song();
    observe(75);
    pause_from = -1;
    pause_to   = -1;
    check_eq("pause_pre_mute", mute_log[14], 0);
    check_eq("pause_mute_start", mute_log[15], 1);
    check_eq("pause_mute_end", mute_log[39], 1);
    check_eq("pause_resume", mute_log[40], 0);
    check_eq("pause_last_play", mute_log[57], 0);
    check_eq("pause_gap", mute_log[58], 1);
    check_eq("pause_note_cycles", unmute[4], 30);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
